// File: rtl/bomb_request.sv
// bomb_request: per-player bomb placement front end.
// Turns button edges into qualified one-cycle placement requests.

module bomb_player #(
  parameter int COOLDOWN = 6,
  parameter int CW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn,
  input  logic [3:0]  x,
  input  logic [3:0]  y,
  input  logic [99:0] occ,
  input  logic        play,
  input  logic        other_v,
  input  logic [3:0]  other_x,
  input  logic [3:0]  other_y,
  input  logic        kill,
  output logic        cand,
  output logic        bomb_v,
  output logic [3:0]  bomb_x,
  output logic [3:0]  bomb_y,
  output logic        ready
);
  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    COOL
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          btn_q;
  logic          hit;
  logic          in_range;
  logic          same_prev;
  logic          accept;
  logic [6:0]    idx;

  assign in_range = (x <= 4'd9) && (y <= 4'd9);
  assign idx = 7'(x) * 7'd10 + 7'(y);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (idx == 7'(i)) hit = occ[i];
    end
  end

  // the other player's last request is not in the map yet
  assign same_prev = other_v
                  && (other_x == x)
                  && (other_y == y);

  assign cand = btn && !btn_q
             && (state_q == IDLE)
             && play && in_range
             && !hit && !same_prev;

  assign accept = cand && !kill;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = FIRE;
      end
      FIRE: begin
        state_d = COOL;
        cnt_d   = CW'(COOLDOWN - 1);
      end
      COOL: begin
        if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      bomb_x  <= 4'd0;
      bomb_y  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn;
      if (accept) begin
        bomb_x <= x;
        bomb_y <= y;
      end
    end
  end

  assign bomb_v = (state_q == FIRE);
  assign ready  = (state_q == IDLE);
endmodule

module bomb_request #(
  parameter int COOLDOWN = 6,
  parameter int CW = 3
) (
  input  logic        bombClk,
  input  logic        rst,
  input  logic        btnA,
  input  logic        btnB,
  input  logic [3:0]  playerAx,
  input  logic [3:0]  playerAy,
  input  logic [3:0]  playerBx,
  input  logic [3:0]  playerBy,
  input  logic [99:0] i_curBombMap_0,
  input  logic [99:0] i_curBombMap_1,
  input  logic [1:0]  game_state,
  output logic        bombA_v,
  output logic [3:0]  bombA_x,
  output logic [3:0]  bombA_y,
  output logic        bombB_v,
  output logic [3:0]  bombB_x,
  output logic [3:0]  bombB_y,
  output logic        readyA,
  output logic        readyB
);
  logic [99:0] occ;
  logic        play;
  logic        cand_a;
  logic        cand_b;
  logic        kill_b;

  assign occ  = i_curBombMap_0 | i_curBombMap_1;
  assign play = (game_state == 2'd0);

  // same cell in the same cycle: A wins
  assign kill_b = cand_a
               && (playerAx == playerBx)
               && (playerAy == playerBy);

  bomb_player #(
    .COOLDOWN(COOLDOWN),
    .CW(CW)
  ) u_a (
    .clk(bombClk),
    .rst(rst),
    .btn(btnA),
    .x(playerAx),
    .y(playerAy),
    .occ(occ),
    .play(play),
    .other_v(bombB_v),
    .other_x(bombB_x),
    .other_y(bombB_y),
    .kill(1'b0),
    .cand(cand_a),
    .bomb_v(bombA_v),
    .bomb_x(bombA_x),
    .bomb_y(bombA_y),
    .ready(readyA)
  );

  bomb_player #(
    .COOLDOWN(COOLDOWN),
    .CW(CW)
  ) u_b (
    .clk(bombClk),
    .rst(rst),
    .btn(btnB),
    .x(playerBx),
    .y(playerBy),
    .occ(occ),
    .play(play),
    .other_v(bombA_v),
    .other_x(bombA_x),
    .other_y(bombA_y),
    .kill(kill_b),
    .cand(cand_b),
    .bomb_v(bombB_v),
    .bomb_x(bombB_x),
    .bomb_y(bombB_y),
    .ready(readyB)
  );
endmodule

// File: tb/tb_bomb_request.sv
// tb_bomb_request: directed and random scenarios against
// a cycle-count reference model of the placement rules.

module tb_bomb_request;
  localparam int COOLDOWN = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        btnA;
  logic        btnB;
  logic [3:0]  ax;
  logic [3:0]  ay;
  logic [3:0]  bx;
  logic [3:0]  by;
  logic [99:0] map0;
  logic [99:0] map1;
  logic [1:0]  gs;
  logic        bombA_v;
  logic [3:0]  bombA_x;
  logic [3:0]  bombA_y;
  logic        bombB_v;
  logic [3:0]  bombB_x;
  logic [3:0]  bombB_y;
  logic        readyA;
  logic        readyB;

  bomb_request #(
    .COOLDOWN(COOLDOWN),
    .CW(3)
  ) dut (
    .bombClk(clk),
    .rst(rst),
    .btnA(btnA),
    .btnB(btnB),
    .playerAx(ax),
    .playerAy(ay),
    .playerBx(bx),
    .playerBy(by),
    .i_curBombMap_0(map0),
    .i_curBombMap_1(map1),
    .game_state(gs),
    .bombA_v(bombA_v),
    .bombA_x(bombA_x),
    .bombA_y(bombA_y),
    .bombB_v(bombB_v),
    .bombB_x(bombB_x),
    .bombB_y(bombB_y),
    .readyA(readyA),
    .readyB(readyB)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: edge index, earliest accept edge per player
  int         e = 0;
  int         fa = 0;
  int         fb = 0;
  bit         pa, pb, va, vb;
  logic [3:0] xa, ya, xb, yb;

  wire [19:0] got = {bombA_v, bombA_x, bombA_y, readyA,
                     bombB_v, bombB_x, bombB_y, readyB};

  localparam logic [19:0] RST_VEC = 20'b0_0000_0000_1_0_0000_0000_1;

  function automatic logic [19:0] expv();
    return {va, xa, ya, e >= fa, vb, xb, yb, e >= fb};
  endfunction

  function automatic bit cell_ok(logic [3:0] x, logic [3:0] y);
    int idx;
    if (x > 9 || y > 9) return 1'b0;
    idx = 10 * int'(x) + int'(y);
    return !(map0[idx] || map1[idx]);
  endfunction

  task automatic model_reset();
    fa = e;
    fb = e;
    pa = 0;
    pb = 0;
    va = 0;
    vb = 0;
    xa = 0;
    ya = 0;
    xb = 0;
    yb = 0;
  endtask

  task automatic step();
    bit ca, cb;
    @(posedge clk);
    ca = btnA && !pa && e >= fa && gs == 0 && cell_ok(ax, ay)
      && !(vb && xb == ax && yb == ay);
    cb = btnB && !pb && e >= fb && gs == 0 && cell_ok(bx, by)
      && !(va && xa == bx && ya == by)
      && !(ca && ax == bx && ay == by);
    pa = btnA;
    pb = btnB;
    va = ca;
    vb = cb;
    if (ca) begin
      xa = ax;
      ya = ay;
      fa = e + COOLDOWN + 2;
    end
    if (cb) begin
      xb = bx;
      yb = by;
      fb = e + COOLDOWN + 2;
    end
    e++;
    #1;
  endtask

  task automatic settle(int n);
    btnA = 0;
    btnB = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 0;
    btnA = 0;
    btnB = 0;
    ax = 0;
    ay = 0;
    bx = 0;
    by = 0;
    map0 = '0;
    map1 = '0;
    gs = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (got !== RST_VEC) begin
        errors++;
        $display("FAIL reset: got %h want %h", got, RST_VEC);
      end
    end
    rst = 1;
    model_reset();
  endtask

  task automatic test_single();
    int pulses = 0;
    int lowr = 0;
    ax = 3;
    ay = 4;
    btnA = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (got !== expv()) begin
        errors++;
        $display("FAIL single: got %h want %h", got, expv());
      end
      pulses += int'(bombA_v);
      lowr += int'(!readyA);
    end
    btnA = 0;
    checks++;
    if (pulses !== 1 || lowr !== 7) begin
      errors++;
      $display("FAIL single_count: pulses %0d low %0d want 1 7",
               pulses, lowr);
    end
    checks++;
    if ({bombA_x, bombA_y} !== 8'h34) begin
      errors++;
      $display("FAIL single_xy: got %h want 34", {bombA_x, bombA_y});
    end
  endtask

  task automatic test_cooldown();
    int acc = 0;
    settle(10);
    for (int i = 0; i < 20; i++) begin
      btnA = (i % 2 == 0);
      step();
      checks++;
      if (got !== expv()) begin
        errors++;
        $display("FAIL cooldown: got %h want %h", got, expv());
      end
      acc += int'(bombA_v);
    end
    checks++;
    if (acc !== 3) begin
      errors++;
      $display("FAIL cooldown_count: got %0d want 3", acc);
    end
  endtask

  task automatic test_occupancy();
    int acc = 0;
    settle(10);
    map0[34] = 1'b1;
    ax = 3;
    ay = 4;
    btnA = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (got !== expv()) begin
        errors++;
        $display("FAIL occupied: got %h want %h", got, expv());
      end
      acc += int'(bombA_v);
    end
    checks++;
    if (acc !== 0 || readyA !== 1'b1) begin
      errors++;
      $display("FAIL occupied_block: pulses %0d ready %b want 0 1",
               acc, readyA);
    end
    btnA = 0;
    map0[34] = 1'b0;
    step();
    btnA = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (got !== expv()) begin
        errors++;
        $display("FAIL freed: got %h want %h", got, expv());
      end
      acc += int'(bombA_v);
    end
    checks++;
    if (acc !== 1) begin
      errors++;
      $display("FAIL freed_count: got %0d want 1", acc);
    end
  endtask

  task automatic test_conflict();
    settle(10);
    ax = 5;
    ay = 5;
    bx = 5;
    by = 5;
    btnA = 1;
    btnB = 1;
    step();
    checks++;
    if ({bombA_v, bombB_v} !== 2'b10 || got !== expv()) begin
      errors++;
      $display("FAIL same_cycle: got %h want %h", got, expv());
    end
    settle(10);
    btnA = 1;
    step();
    btnB = 1;
    step();
    checks++;
    if ({bombB_v, readyB} !== 2'b01 || got !== expv()) begin
      errors++;
      $display("FAIL prev_cycle: got %h want %h", got, expv());
    end
  endtask

  task automatic test_game_over();
    int acc = 0;
    int lowb = 0;
    settle(10);
    bx = 7;
    by = 1;
    btnB = 1;
    step();
    lowb += int'(!readyB);
    btnB = 0;
    gs = 2;
    ax = 2;
    ay = 2;
    btnA = 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) gs = 0;
      step();
      checks++;
      if (got !== expv()) begin
        errors++;
        $display("FAIL game_over: got %h want %h", got, expv());
      end
      acc += int'(bombA_v);
      lowb += int'(!readyB);
    end
    checks++;
    if (acc !== 0 || lowb !== 7) begin
      errors++;
      $display("FAIL game_over_count: a %0d lowb %0d want 0 7",
               acc, lowb);
    end
  endtask

  task automatic test_async_reset();
    settle(10);
    ax = 1;
    ay = 1;
    btnA = 1;
    bx = 8;
    by = 8;
    btnB = 1;
    for (int i = 0; i < 3; i++) step();
    #2;
    rst = 0;
    #1;
    checks++;
    if (got !== RST_VEC) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", got, RST_VEC);
    end
    #1;
    rst = 1;
    model_reset();
    step();
    checks++;
    if ({bombA_v, bombA_x, bombA_y} !== 9'h111 || got !== expv()) begin
      errors++;
      $display("FAIL after_reset: got %h want %h", got, expv());
    end
  endtask

  task automatic test_random();
    settle(10);
    for (int i = 0; i < 600; i++) begin
      btnA = ($urandom_range(0, 2) != 0);
      btnB = ($urandom_range(0, 2) != 0);
      ax = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                       : 4'($urandom_range(0, 2));
      ay = 4'($urandom_range(0, 2));
      bx = 4'($urandom_range(0, 2));
      by = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                       : 4'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0)
        map0[$urandom_range(0, 22)] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        map1[$urandom_range(0, 22)] = 1'($urandom_range(0, 1));
      gs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      step();
      checks++;
      if (got !== expv()) begin
        errors++;
        $display("FAIL random %0d: got %h want %h", i, got, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_cooldown();
    test_occupancy();
    test_conflict();
    test_game_over();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
